// File: rtl/am29xx_bitslice_pair_pkg.sv
// rtl/am29xx_bitslice_pair_pkg.sv - shared encodings for the sequencer and ALU bit slices
package am29xx_bitslice_pair_pkg;

    localparam logic [1:0] SEQ_UPC = 2'd0;
    localparam logic [1:0] SEQ_AR  = 2'd1;
    localparam logic [1:0] SEQ_STK = 2'd2;
    localparam logic [1:0] SEQ_D   = 2'd3;

    localparam logic [2:0] SRC_AQ = 3'd0;
    localparam logic [2:0] SRC_AB = 3'd1;
    localparam logic [2:0] SRC_ZQ = 3'd2;
    localparam logic [2:0] SRC_ZB = 3'd3;
    localparam logic [2:0] SRC_ZA = 3'd4;
    localparam logic [2:0] SRC_DA = 3'd5;
    localparam logic [2:0] SRC_DQ = 3'd6;
    localparam logic [2:0] SRC_DZ = 3'd7;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUBR  = 3'd1;
    localparam logic [2:0] OP_SUBS  = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_NOTRS = 3'd5;
    localparam logic [2:0] OP_EXOR  = 3'd6;
    localparam logic [2:0] OP_EXNOR = 3'd7;

    localparam logic [2:0] DST_QREG  = 3'd0;
    localparam logic [2:0] DST_NOP   = 3'd1;
    localparam logic [2:0] DST_RAMA  = 3'd2;
    localparam logic [2:0] DST_RAMF  = 3'd3;
    localparam logic [2:0] DST_RAMQD = 3'd4;
    localparam logic [2:0] DST_RAMD  = 3'd5;
    localparam logic [2:0] DST_RAMQU = 3'd6;
    localparam logic [2:0] DST_RAMU  = 3'd7;

    function automatic logic is_arith(input logic [2:0] op);
        return op <= OP_SUBS;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - 4-bit ALU slice (Am2901) with 16x4 register file and Q register
module alu_slice
    import am29xx_bitslice_pair_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] src,
    input  logic [2:0] op,
    input  logic [2:0] dest,
    input  logic       cin,
    input  logic       ram0_in,
    input  logic       ram3_in,
    input  logic       q0_in,
    input  logic       q3_in,
    output logic [3:0] y,
    output logic       cout,
    output logic       f0,
    output logic       f3,
    output logic       ovr,
    output logic       ram0_out,
    output logic       ram3_out,
    output logic       q0_out,
    output logic       q3_out
);

    logic [3:0] ram [16];
    logic [3:0] q;
    logic [3:0] a_val, b_val;
    logic [3:0] r_op, s_op, r_in, s_in, f;
    logic [4:0] sum;
    logic       arith, c3;

    assign a_val = ram[a];
    assign b_val = ram[b];

    always_comb begin
        r_op = d;
        s_op = 4'h0;
        case (src)
            SRC_AQ:  begin r_op = a_val; s_op = q;     end
            SRC_AB:  begin r_op = a_val; s_op = b_val; end
            SRC_ZQ:  begin r_op = 4'h0;  s_op = q;     end
            SRC_ZB:  begin r_op = 4'h0;  s_op = b_val; end
            SRC_ZA:  begin r_op = 4'h0;  s_op = a_val; end
            SRC_DA:  begin r_op = d;     s_op = a_val; end
            SRC_DQ:  begin r_op = d;     s_op = q;     end
            default: begin r_op = d;     s_op = 4'h0;  end
        endcase
    end

    assign arith = is_arith(op);
    assign r_in  = (op == OP_SUBR) ? ~r_op : r_op;
    assign s_in  = (op == OP_SUBS) ? ~s_op : s_op;
    assign sum   = {1'b0, r_in} + {1'b0, s_in} + {4'h0, cin};
    // Carry into bit 3 recovered from the bit-3 sum and its two operand bits.
    assign c3    = r_in[3] ^ s_in[3] ^ sum[3];

    always_comb begin
        f = sum[3:0];
        case (op)
            OP_OR:    f = r_op | s_op;
            OP_AND:   f = r_op & s_op;
            OP_NOTRS: f = ~r_op & s_op;
            OP_EXOR:  f = r_op ^ s_op;
            OP_EXNOR: f = ~(r_op ^ s_op);
            default:  f = sum[3:0];
        endcase
    end

    assign cout     = arith & sum[4];
    assign ovr      = arith & (c3 ^ sum[4]);
    assign f0       = (f == 4'h0);
    assign f3       = f[3];
    assign y        = (dest == DST_RAMA) ? a_val : f;
    assign ram0_out = f[0];
    assign ram3_out = f[3];
    assign q0_out   = q[0];
    assign q3_out   = q[3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= 4'h0;
            for (int i = 0; i < 16; i++) ram[i] <= 4'h0;
        end else begin
            case (dest)
                DST_QREG:  q <= f;
                DST_RAMA,
                DST_RAMF:  ram[b] <= f;
                DST_RAMQD: begin
                    ram[b] <= {ram3_in, f[3:1]};
                    q      <= {q3_in, q[3:1]};
                end
                DST_RAMD:  ram[b] <= {ram3_in, f[3:1]};
                DST_RAMQU: begin
                    ram[b] <= {f[2:0], ram0_in};
                    q      <= {q[2:0], q0_in};
                end
                DST_RAMU:  ram[b] <= {f[2:0], ram0_in};
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/seq_slice.sv
// rtl/seq_slice.sv - 4-bit microprogram sequencer slice (Am2909, or Am2911 when AM2911=1)
module seq_slice
    import am29xx_bitslice_pair_pkg::*;
#(
    parameter bit AM2911 = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    input  logic [3:0] r,
    input  logic [3:0] orm,
    input  logic [1:0] s,
    input  logic       zero_n,
    input  logic       cin,
    input  logic       re_n,
    input  logic       fe_n,
    input  logic       pup,
    output logic [3:0] y,
    output logic       cout
);

    logic [3:0] upc;
    logic [3:0] ar;
    logic [3:0] mux;
    logic [3:0] inc;
    logic [1:0] sp;
    logic [1:0] sp_up;
    logic [3:0] stack [4];

    always_comb begin
        mux = upc;
        case (s)
            SEQ_AR:  mux = ar;
            SEQ_STK: mux = stack[sp];
            SEQ_D:   mux = d;
            default: mux = upc;
        endcase
    end

    assign y           = (mux | (AM2911 ? 4'h0 : orm)) & {4{zero_n}};
    assign {cout, inc} = {1'b0, y} + {4'h0, cin};
    assign sp_up       = sp + 2'd1;

    // A push saves the pre-increment uPC; the pointer wraps freely in both directions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc <= 4'h0;
            ar  <= 4'h0;
            sp  <= 2'd0;
            for (int i = 0; i < 4; i++) stack[i] <= 4'h0;
        end else begin
            upc <= inc;
            if (!re_n) ar <= AM2911 ? d : r;
            if (!fe_n) begin
                if (pup) begin
                    sp           <= sp_up;
                    stack[sp_up] <= upc;
                end else begin
                    sp <= sp - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/am29xx_bitslice_pair.sv
// rtl/am29xx_bitslice_pair.sv - one sequencer slice and one ALU slice on a shared clock/reset
module am29xx_bitslice_pair #(
    parameter bit AM2911 = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] seq_d,
    input  logic [3:0] seq_r,
    input  logic [3:0] seq_or,
    input  logic [1:0] seq_s,
    input  logic       seq_zero_n,
    input  logic       seq_cin,
    input  logic       seq_re_n,
    input  logic       seq_fe_n,
    input  logic       seq_pup,
    output logic [3:0] seq_y,
    output logic       seq_cout,
    input  logic [3:0] alu_d,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    input  logic [2:0] alu_src,
    input  logic [2:0] alu_op,
    input  logic [2:0] alu_dest,
    input  logic       alu_cin,
    input  logic       alu_ram0_in,
    input  logic       alu_ram3_in,
    input  logic       alu_q0_in,
    input  logic       alu_q3_in,
    output logic [3:0] alu_y,
    output logic       alu_cout,
    output logic       alu_f0,
    output logic       alu_f3,
    output logic       alu_ovr,
    output logic       alu_ram0_out,
    output logic       alu_ram3_out,
    output logic       alu_q0_out,
    output logic       alu_q3_out
);

    seq_slice #(.AM2911(AM2911)) u_seq (
        .clock  (clock),
        .reset  (reset),
        .d      (seq_d),
        .r      (seq_r),
        .orm    (seq_or),
        .s      (seq_s),
        .zero_n (seq_zero_n),
        .cin    (seq_cin),
        .re_n   (seq_re_n),
        .fe_n   (seq_fe_n),
        .pup    (seq_pup),
        .y      (seq_y),
        .cout   (seq_cout)
    );

    alu_slice u_alu (
        .clock    (clock),
        .reset    (reset),
        .d        (alu_d),
        .a        (alu_a),
        .b        (alu_b),
        .src      (alu_src),
        .op       (alu_op),
        .dest     (alu_dest),
        .cin      (alu_cin),
        .ram0_in  (alu_ram0_in),
        .ram3_in  (alu_ram3_in),
        .q0_in    (alu_q0_in),
        .q3_in    (alu_q3_in),
        .y        (alu_y),
        .cout     (alu_cout),
        .f0       (alu_f0),
        .f3       (alu_f3),
        .ovr      (alu_ovr),
        .ram0_out (alu_ram0_out),
        .ram3_out (alu_ram3_out),
        .q0_out   (alu_q0_out),
        .q3_out   (alu_q3_out)
    );

endmodule

// File: tb/tb_am29xx_bitslice_pair.sv
// tb/tb_am29xx_bitslice_pair.sv - vector-table bench for the Am2909/Am2911 + Am2901 slice pair
module tb_am29xx_bitslice_pair;
    import am29xx_bitslice_pair_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] seq_d, seq_r, seq_or;
    logic [1:0] seq_s;
    logic       seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup;
    logic [3:0] seq_y, b_seq_y;
    logic       seq_cout, b_seq_cout;
    logic [3:0] alu_d, alu_a, alu_b;
    logic [2:0] alu_src, alu_op, alu_dest;
    logic       alu_cin, alu_ram0_in, alu_ram3_in, alu_q0_in, alu_q3_in;
    logic [3:0] alu_y, b_alu_y;
    logic       alu_cout, alu_f0, alu_f3, alu_ovr;
    logic       alu_ram0_out, alu_ram3_out, alu_q0_out, alu_q3_out;
    logic       b_alu_cout, b_alu_f0, b_alu_f3, b_alu_ovr;
    logic       b_alu_ram0_out, b_alu_ram3_out, b_alu_q0_out, b_alu_q3_out;

    always #5 clock = ~clock;

    am29xx_bitslice_pair #(.AM2911(1'b0)) dut (
        .clock(clock), .reset(reset),
        .seq_d(seq_d), .seq_r(seq_r), .seq_or(seq_or), .seq_s(seq_s),
        .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n),
        .seq_fe_n(seq_fe_n), .seq_pup(seq_pup), .seq_y(seq_y), .seq_cout(seq_cout),
        .alu_d(alu_d), .alu_a(alu_a), .alu_b(alu_b), .alu_src(alu_src),
        .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
        .alu_ram0_in(alu_ram0_in), .alu_ram3_in(alu_ram3_in),
        .alu_q0_in(alu_q0_in), .alu_q3_in(alu_q3_in),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_f0(alu_f0), .alu_f3(alu_f3),
        .alu_ovr(alu_ovr), .alu_ram0_out(alu_ram0_out), .alu_ram3_out(alu_ram3_out),
        .alu_q0_out(alu_q0_out), .alu_q3_out(alu_q3_out)
    );

    am29xx_bitslice_pair #(.AM2911(1'b1)) dut_2911 (
        .clock(clock), .reset(reset),
        .seq_d(seq_d), .seq_r(seq_r), .seq_or(seq_or), .seq_s(seq_s),
        .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n),
        .seq_fe_n(seq_fe_n), .seq_pup(seq_pup), .seq_y(b_seq_y), .seq_cout(b_seq_cout),
        .alu_d(alu_d), .alu_a(alu_a), .alu_b(alu_b), .alu_src(alu_src),
        .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
        .alu_ram0_in(alu_ram0_in), .alu_ram3_in(alu_ram3_in),
        .alu_q0_in(alu_q0_in), .alu_q3_in(alu_q3_in),
        .alu_y(b_alu_y), .alu_cout(b_alu_cout), .alu_f0(b_alu_f0), .alu_f3(b_alu_f3),
        .alu_ovr(b_alu_ovr), .alu_ram0_out(b_alu_ram0_out), .alu_ram3_out(b_alu_ram3_out),
        .alu_q0_out(b_alu_q0_out), .alu_q3_out(b_alu_q3_out)
    );

    typedef struct {
        logic [1:0] s;
        logic [3:0] d, r, orm;
        logic       zero_n, cin, re_n, fe_n, pup;
        logic [3:0] y;
        logic       cout;
        logic [3:0] y11;
    } seq_vec_t;

    // flags = {cout, f0, f3, ovr}; sh = {ram3_out, ram0_out, q3_out, q0_out}
    typedef struct {
        logic [2:0] src, op, dest;
        logic [3:0] a, b, d;
        logic       cin, ram0_in, ram3_in, q0_in, q3_in;
        logic [3:0] y, flags, sh;
    } alu_vec_t;

    typedef struct {
        string       name;
        logic        is_alu;
        logic [11:0] exp;
    } exp_t;

    exp_t     sb[$];
    seq_vec_t seq_tab[$];
    alu_vec_t alu_tab[$];
    int       n_vec  = 0;
    int       n_miss = 0;

    function automatic seq_vec_t sv(input logic [1:0] s, input logic [3:0] d, r, orm,
                                    input logic zero_n, cin, re_n, fe_n, pup,
                                    input logic [3:0] y, input logic cout, input logic [3:0] y11);
        seq_vec_t v;
        v = '{s, d, r, orm, zero_n, cin, re_n, fe_n, pup, y, cout, y11};
        return v;
    endfunction

    function automatic alu_vec_t av(input logic [2:0] src, op, dest, input logic [3:0] a, b, d,
                                    input logic cin, ram0_in, ram3_in, q0_in, q3_in,
                                    input logic [3:0] y, flags, sh);
        alu_vec_t v;
        v = '{src, op, dest, a, b, d, cin, ram0_in, ram3_in, q0_in, q3_in, y, flags, sh};
        return v;
    endfunction

    task automatic push_seq(input string n, input logic [3:0] y, input logic c, input logic [3:0] y11);
        exp_t e;
        e = '{n, 1'b0, {3'b000, y, c, y11}};
        sb.push_back(e);
    endtask

    task automatic push_alu(input string n, input logic [3:0] y, flags, sh);
        exp_t e;
        e = '{n, 1'b1, {y, flags, sh}};
        sb.push_back(e);
    endtask

    task automatic flush();
        exp_t        e;
        logic [11:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_alu)
                act = {alu_y, alu_cout, alu_f0, alu_f3, alu_ovr,
                       alu_ram3_out, alu_ram0_out, alu_q3_out, alu_q0_out};
            else
                act = {3'b000, seq_y, seq_cout, b_seq_y};
            n_vec++;
            if (act !== e.exp) begin
                n_miss++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        flush();
        @(posedge clock);
        #1;
    endtask

    task automatic seq_idle();
        seq_s = SEQ_UPC; seq_d = 4'h0; seq_r = 4'h0; seq_or = 4'h0;
        seq_zero_n = 1'b1; seq_cin = 1'b0; seq_re_n = 1'b1; seq_fe_n = 1'b1; seq_pup = 1'b0;
    endtask

    task automatic alu_idle();
        alu_src = SRC_AQ; alu_op = OP_OR; alu_dest = DST_NOP;
        alu_a = 4'h0; alu_b = 4'h0; alu_d = 4'h0; alu_cin = 1'b0;
        alu_ram0_in = 1'b0; alu_ram3_in = 1'b0; alu_q0_in = 1'b0; alu_q3_in = 1'b0;
    endtask

    initial begin
        //                 s  d     r     or    zn cin re fe pup  y     cout y2911
        seq_tab.push_back(sv(3, 4'h5, 4'h0, 4'h0, 1, 1, 1, 1, 0, 4'h5, 0, 4'h5));
        seq_tab.push_back(sv(3, 4'h5, 4'h0, 4'h0, 1, 1, 1, 0, 1, 4'h5, 0, 4'h5));
        seq_tab.push_back(sv(2, 4'h0, 4'h0, 4'h0, 1, 1, 1, 0, 0, 4'h6, 0, 4'h6));
        seq_tab.push_back(sv(2, 4'h0, 4'h0, 4'h0, 1, 0, 1, 1, 0, 4'h0, 0, 4'h0));
        seq_tab.push_back(sv(3, 4'h8, 4'h0, 4'h3, 1, 0, 1, 1, 0, 4'hB, 0, 4'h8));
        seq_tab.push_back(sv(3, 4'h8, 4'h0, 4'h3, 0, 0, 1, 1, 0, 4'h0, 0, 4'h0));
        seq_tab.push_back(sv(3, 4'h9, 4'h4, 4'h0, 1, 0, 0, 1, 0, 4'h9, 0, 4'h9));
        seq_tab.push_back(sv(1, 4'h0, 4'h0, 4'h0, 1, 1, 1, 1, 0, 4'h4, 0, 4'h9));
        seq_tab.push_back(sv(3, 4'hF, 4'h0, 4'h0, 1, 1, 1, 1, 0, 4'hF, 1, 4'hF));
        seq_tab.push_back(sv(0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 1, 0, 4'h0, 0, 4'h0));
        seq_tab.push_back(sv(3, 4'hA, 4'h0, 4'h0, 1, 1, 1, 1, 0, 4'hA, 0, 4'hA));
        seq_tab.push_back(sv(0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 0, 0, 4'hB, 0, 4'hB));
        seq_tab.push_back(sv(0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 0, 1, 4'hB, 0, 4'hB));
        seq_tab.push_back(sv(2, 4'h0, 4'h0, 4'h0, 1, 1, 1, 1, 0, 4'hB, 0, 4'hB));

        //                    src     op        dest       a     b     d    cin r0 r3 q0 q3  y      flags    sh
        alu_tab.push_back(av(SRC_DZ, OP_ADD,   DST_RAMF,  4'h0, 4'h1, 4'h7, 0, 0, 0, 0, 0, 4'h7, 4'b0000, 4'b0100));
        alu_tab.push_back(av(SRC_AB, OP_ADD,   DST_NOP,   4'h1, 4'h1, 4'h0, 0, 0, 0, 0, 0, 4'hE, 4'b0011, 4'b1000));
        alu_tab.push_back(av(SRC_DZ, OP_ADD,   DST_RAMF,  4'h0, 4'h2, 4'h5, 0, 0, 0, 0, 0, 4'h5, 4'b0000, 4'b0100));
        alu_tab.push_back(av(SRC_DA, OP_SUBR,  DST_NOP,   4'h2, 4'h0, 4'h5, 1, 0, 0, 0, 0, 4'h0, 4'b1100, 4'b0000));
        alu_tab.push_back(av(SRC_DZ, OP_ADD,   DST_RAMF,  4'h0, 4'h3, 4'h9, 0, 0, 0, 0, 0, 4'h9, 4'b0010, 4'b1100));
        alu_tab.push_back(av(SRC_ZB, OP_ADD,   DST_RAMD,  4'h0, 4'h3, 4'h0, 0, 0, 1, 0, 0, 4'h9, 4'b0010, 4'b1100));
        alu_tab.push_back(av(SRC_ZB, OP_OR,    DST_NOP,   4'h0, 4'h3, 4'h0, 0, 0, 0, 0, 0, 4'hC, 4'b0010, 4'b1000));
        alu_tab.push_back(av(SRC_DZ, OP_ADD,   DST_QREG,  4'h0, 4'h0, 4'h8, 0, 0, 0, 0, 0, 4'h8, 4'b0010, 4'b1000));
        alu_tab.push_back(av(SRC_ZQ, OP_OR,    DST_RAMQU, 4'h0, 4'h4, 4'h0, 0, 1, 0, 1, 0, 4'h8, 4'b0010, 4'b1010));
        alu_tab.push_back(av(SRC_ZQ, OP_OR,    DST_NOP,   4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h1, 4'b0000, 4'b0101));
        alu_tab.push_back(av(SRC_ZB, OP_OR,    DST_NOP,   4'h0, 4'h4, 4'h0, 0, 0, 0, 0, 0, 4'h1, 4'b0000, 4'b0101));
        alu_tab.push_back(av(SRC_AB, OP_AND,   DST_RAMA,  4'h1, 4'h5, 4'h0, 0, 0, 0, 0, 0, 4'h7, 4'b0100, 4'b0001));
        alu_tab.push_back(av(SRC_AB, OP_EXOR,  DST_RAMA,  4'h1, 4'h6, 4'h0, 0, 0, 0, 0, 0, 4'h7, 4'b0000, 4'b0101));
        alu_tab.push_back(av(SRC_ZA, OP_ADD,   DST_NOP,   4'h6, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h8, 4'b0011, 4'b1001));
        alu_tab.push_back(av(SRC_DA, OP_SUBS,  DST_NOP,   4'h6, 4'h0, 4'h3, 0, 0, 0, 0, 0, 4'hB, 4'b0010, 4'b1101));
        alu_tab.push_back(av(SRC_DQ, OP_EXNOR, DST_NOP,   4'h0, 4'h0, 4'hA, 0, 0, 0, 0, 0, 4'h4, 4'b0000, 4'b0001));
        alu_tab.push_back(av(SRC_DA, OP_NOTRS, DST_NOP,   4'h1, 4'h0, 4'h3, 0, 0, 0, 0, 0, 4'h4, 4'b0000, 4'b0001));
        alu_tab.push_back(av(SRC_ZQ, OP_OR,    DST_RAMQD, 4'h0, 4'h7, 4'h0, 0, 0, 0, 0, 1, 4'h1, 4'b0000, 4'b0101));
        alu_tab.push_back(av(SRC_ZQ, OP_OR,    DST_NOP,   4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h8, 4'b0010, 4'b1010));
        alu_tab.push_back(av(SRC_ZB, OP_OR,    DST_RAMU,  4'h0, 4'h6, 4'h0, 0, 0, 0, 0, 0, 4'h7, 4'b0000, 4'b0110));
        alu_tab.push_back(av(SRC_ZB, OP_OR,    DST_NOP,   4'h0, 4'h6, 4'h0, 0, 0, 0, 0, 0, 4'hE, 4'b0010, 4'b1010));
        alu_tab.push_back(av(SRC_AB, OP_ADD,   DST_RAMF,  4'h6, 4'h6, 4'h0, 0, 0, 0, 0, 0, 4'hC, 4'b1010, 4'b1010));
        alu_tab.push_back(av(SRC_ZB, OP_OR,    DST_NOP,   4'h0, 4'h6, 4'h0, 0, 0, 0, 0, 0, 4'hC, 4'b0010, 4'b1010));
        alu_tab.push_back(av(SRC_AQ, OP_ADD,   DST_NOP,   4'h6, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h4, 4'b1001, 4'b0010));

        seq_idle();
        alu_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        push_seq("reset_seq", 4'h0, 1'b0, 4'h0);
        push_alu("reset_alu", 4'h0, 4'b0100, 4'b0000);
        flush();
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 17; i++) begin
            seq_s = SEQ_UPC;
            seq_cin = 1'b1;
            push_seq($sformatf("count%0d", i), 4'(i % 16), (i == 15), 4'(i % 16));
            step();
        end

        foreach (seq_tab[i]) begin
            seq_s = seq_tab[i].s; seq_d = seq_tab[i].d; seq_r = seq_tab[i].r;
            seq_or = seq_tab[i].orm; seq_zero_n = seq_tab[i].zero_n; seq_cin = seq_tab[i].cin;
            seq_re_n = seq_tab[i].re_n; seq_fe_n = seq_tab[i].fe_n; seq_pup = seq_tab[i].pup;
            push_seq($sformatf("seq_vec%0d", i), seq_tab[i].y, seq_tab[i].cout, seq_tab[i].y11);
            step();
        end
        seq_idle();

        foreach (alu_tab[i]) begin
            alu_src = alu_tab[i].src; alu_op = alu_tab[i].op; alu_dest = alu_tab[i].dest;
            alu_a = alu_tab[i].a; alu_b = alu_tab[i].b; alu_d = alu_tab[i].d;
            alu_cin = alu_tab[i].cin; alu_ram0_in = alu_tab[i].ram0_in;
            alu_ram3_in = alu_tab[i].ram3_in; alu_q0_in = alu_tab[i].q0_in;
            alu_q3_in = alu_tab[i].q3_in;
            push_alu($sformatf("alu_vec%0d", i), alu_tab[i].y, alu_tab[i].flags, alu_tab[i].sh);
            step();
        end

        // Reset mid-cycle while a RAM write is pending; uPC is 0xC at this point.
        alu_src = SRC_DZ; alu_op = OP_ADD; alu_dest = DST_RAMF; alu_b = 4'h8; alu_d = 4'hF;
        @(negedge clock);
        reset = 1'b1;
        #1;
        push_seq("async_reset_seq", 4'h0, 1'b0, 4'h0);
        push_alu("async_reset_alu", 4'hF, 4'b0010, 4'b1100);
        flush();
        @(posedge clock);
        #1;
        reset = 1'b0;
        alu_idle();
        alu_src = SRC_ZB; alu_b = 4'h8;
        push_seq("post_reset_seq", 4'h0, 1'b0, 4'h0);
        push_alu("post_reset_r8", 4'h0, 4'b0100, 4'b0000);
        step();
        alu_src = SRC_ZA; alu_a = 4'h1;
        push_alu("post_reset_r1", 4'h0, 4'b0100, 4'b0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
